// File: rtl/mapper_noc_ni.sv
// Network interface between a NoC router port and a MapReduce mapper core.
// Router text is buffered and paced into the core; core pair records stream back out.
module mapper_noc_ni #(
    parameter int DW         = 32,
    parameter int KEY_WORDS  = 4,
    parameter int PAIR_WORDS = 4,
    parameter int TEXT_DEPTH = 64,
    parameter int PAIR_DEPTH = 16,
    parameter int WR_GAP     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic          data_in_ready,
    input  logic          fifo_in_ready,
    output logic [DW-1:0] data_out,
    output logic          data_out_ready,
    output logic [DW-1:0] key_out,
    output logic          key_en,
    output logic [DW-1:0] text_out,
    output logic          data_wr,
    input  logic [DW-1:0] pair_in,
    input  logic          pair_in_valid,
    output logic          pair_full,
    output logic          text_ovf,
    output logic          done
);
    // state    | meaning
    // IDLE     | waiting for keyword word 0
    // KEYWORD  | forwarding remaining keyword words to the core
    // LEN      | waiting for the text length header
    // TEXT     | buffering router text and pacing it into the core
    // FLUSH    | waiting for pair traffic to drain before done

    localparam int TAW = $clog2(TEXT_DEPTH);
    localparam int PAW = $clog2(PAIR_DEPTH);
    localparam int KIW = $clog2(KEY_WORDS + 1);
    localparam int PWW = (PAIR_WORDS > 1) ? $clog2(PAIR_WORDS) : 1;
    localparam int GW  = $clog2(WR_GAP);
    localparam int QW  = $clog2(WR_GAP + 1);

    localparam logic [KIW-1:0] KEY_LAST  = KIW'(KEY_WORDS - 1);
    localparam logic [PWW-1:0] PW_LAST   = PWW'(PAIR_WORDS - 1);
    localparam logic [GW-1:0]  GAP_LOAD  = GW'(WR_GAP - 1);
    localparam logic [QW-1:0]  QUIET_LD  = QW'(WR_GAP);
    localparam logic [PAW:0]   PAIR_CAP  = (PAW+1)'(PAIR_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KEYWORD = 3'd1,
        S_LEN     = 3'd2,
        S_TEXT    = 3'd3,
        S_FLUSH   = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [KIW-1:0] key_idx;
    logic [15:0]    len_q;
    logic [15:0]    rx_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [QW-1:0]  quiet_cnt;

    logic [DW-1:0]  text_mem [TEXT_DEPTH];
    logic [TAW:0]   tw_ptr, tr_ptr;
    logic           text_full, text_empty;

    logic [DW-1:0]  pair_mem [PAIR_DEPTH][PAIR_WORDS];
    logic [PAW:0]   pw_rec, pr_rec, pair_cnt;
    logic [PWW-1:0] pw_word, pr_word;

    logic rx_open, pair_idle, pair_accept, egress_fire;
    logic key_load, len_load, text_rx, feed_pop, job_done;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign text_empty = (tw_ptr == tr_ptr);
    assign text_full  = (tw_ptr[TAW] != tr_ptr[TAW]) && (tw_ptr[TAW-1:0] == tr_ptr[TAW-1:0]);
    assign rx_open    = (rx_cnt != len_q);

    assign pair_cnt    = pw_rec - pr_rec;
    assign pair_full   = (pair_cnt == PAIR_CAP);
    assign pair_accept = pair_in_valid && !pair_full;
    assign egress_fire = (pair_cnt != '0) && fifo_in_ready;
    assign pair_idle   = (pair_cnt == '0) && (pw_word == '0) && (quiet_cnt == '0) && !pair_in_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (data_in_ready) state_nx = (KEY_WORDS == 1) ? S_LEN : S_KEYWORD;
            S_KEYWORD: if (data_in_ready && key_idx == KEY_LAST) state_nx = S_LEN;
            S_LEN:     if (data_in_ready) state_nx = (data_in[15:0] == 16'd0) ? S_FLUSH : S_TEXT;
            S_TEXT:    if (!rx_open && text_empty) state_nx = S_FLUSH;
            S_FLUSH:   if (pair_idle) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        key_load = 1'b0;
        len_load = 1'b0;
        text_rx  = 1'b0;
        feed_pop = 1'b0;
        job_done = 1'b0;
        case (state)
            S_IDLE, S_KEYWORD: key_load = data_in_ready;
            S_LEN:             len_load = data_in_ready;
            S_TEXT: begin
                text_rx  = data_in_ready && rx_open;
                feed_pop = (gap_cnt == '0) && !text_empty;
            end
            S_FLUSH:           job_done = pair_idle;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (text_rx && !text_full) text_mem[tw_ptr[TAW-1:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_out  <= '0;
            key_en   <= 1'b0;
            key_idx  <= '0;
            len_q    <= '0;
            rx_cnt   <= '0;
            tw_ptr   <= '0;
            tr_ptr   <= '0;
            gap_cnt  <= '0;
            text_out <= '0;
            data_wr  <= 1'b0;
            text_ovf <= 1'b0;
            done     <= 1'b0;
        end else begin
            key_en  <= key_load;
            data_wr <= feed_pop;
            done    <= job_done;
            if (key_load) begin
                key_out <= data_in;
                key_idx <= (state == S_IDLE) ? KIW'(1) : key_idx + 1'b1;
            end
            if (len_load) begin
                len_q  <= data_in[15:0];
                rx_cnt <= '0;
            end
            if (text_rx) begin
                rx_cnt <= rx_cnt + 16'd1;
                if (text_full) text_ovf <= 1'b1;
                else           tw_ptr   <= tw_ptr + 1'b1;
            end
            // Core pacing timer: reload on each pop, wait at zero for data.
            if (state != S_TEXT)   gap_cnt <= '0;
            else if (feed_pop)     gap_cnt <= GAP_LOAD;
            else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            if (feed_pop) begin
                text_out <= text_mem[tr_ptr[TAW-1:0]];
                tr_ptr   <= tr_ptr + 1'b1;
            end
            if (job_done) text_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (pair_accept) pair_mem[pw_rec[PAW-1:0]][pw_word] <= pair_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pw_rec         <= '0;
            pw_word        <= '0;
            pr_rec         <= '0;
            pr_word        <= '0;
            quiet_cnt      <= '0;
            data_out       <= '0;
            data_out_ready <= 1'b0;
        end else begin
            if (pair_accept) begin
                if (pw_word == PW_LAST) begin
                    pw_word <= '0;
                    pw_rec  <= pw_rec + 1'b1;
                end else begin
                    pw_word <= pw_word + 1'b1;
                end
            end
            if (egress_fire) begin
                data_out       <= pair_mem[pr_rec[PAW-1:0]][pr_word];
                data_out_ready <= 1'b1;
                if (pr_word == PW_LAST) begin
                    pr_word <= '0;
                    pr_rec  <= pr_rec + 1'b1;
                end else begin
                    pr_word <= pr_word + 1'b1;
                end
            end else begin
                data_out       <= '0;
                data_out_ready <= 1'b0;
            end
            // Quiet timer: FLUSH may only finish once the core has been silent.
            if (pair_in_valid)        quiet_cnt <= QUIET_LD;
            else if (quiet_cnt != '0) quiet_cnt <= quiet_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_mapper_noc_ni.sv
// Scoreboard bench for mapper_noc_ni: random jobs and pair traffic checked
// against queue-based expectations derived from the interface behaviour.
module tb_mapper_noc_ni;
    localparam int DW = 32, KEY_WORDS = 4, PAIR_WORDS = 4;
    localparam int TEXT_DEPTH = 64, PAIR_DEPTH = 16, WR_GAP = 6;

    logic          clk = 1'b0, rst = 1'b1;
    logic [DW-1:0] data_in = '0, pair_in = '0;
    logic          data_in_ready = 1'b0, fifo_in_ready = 1'b0, pair_in_valid = 1'b0;
    logic [DW-1:0] data_out, key_out, text_out;
    logic          data_out_ready, key_en, data_wr, pair_full, text_ovf, done;

    mapper_noc_ni #(
        .DW(DW), .KEY_WORDS(KEY_WORDS), .PAIR_WORDS(PAIR_WORDS),
        .TEXT_DEPTH(TEXT_DEPTH), .PAIR_DEPTH(PAIR_DEPTH), .WR_GAP(WR_GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_ready(data_in_ready), .fifo_in_ready(fifo_in_ready),
        .data_out(data_out), .data_out_ready(data_out_ready),
        .key_out(key_out), .key_en(key_en), .text_out(text_out), .data_wr(data_wr),
        .pair_in(pair_in), .pair_in_valid(pair_in_valid), .pair_full(pair_full),
        .text_ovf(text_ovf), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    logic [DW-1:0] exp_key[$], exp_text[$], exp_pair[$], rcv_text[$], sent_text[$];
    bit ovf_mode = 0, wr_first = 1, fri_prev = 0;
    int cyc = 0, last_wr = 0, wr_total = 0, done_cnt = 0, pair_seen = 0, jobs_exp = 0;
    int fifo_mode = 0, phase = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(string name, logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected output 0x%0h", name, act);
    endtask

    always @(posedge clk) begin
        cyc++;
        fri_prev = fifo_in_ready;
    end

    // Router readiness driver
    initial forever begin
        @(posedge clk);
        #1;
        case (fifo_mode)
            0: fifo_in_ready = 1'b1;
            1: fifo_in_ready = (phase % 3) != 2;
            2: fifo_in_ready = 1'($urandom_range(1, 0));
            default: fifo_in_ready = 1'b0;
        endcase
        phase++;
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (key_en === 1'b1) begin
            if (exp_key.size() == 0) flag("key_unexpected", key_out);
            else check("key_out", key_out, exp_key.pop_front());
        end
        if (data_wr === 1'b1) begin
            wr_total++;
            if (!wr_first) check("wr_gap", cyc - last_wr, WR_GAP);
            wr_first = 0;
            last_wr  = cyc;
            if (ovf_mode) rcv_text.push_back(text_out);
            else if (exp_text.size() == 0) flag("text_unexpected", text_out);
            else check("text_out", text_out, exp_text.pop_front());
        end
        if (data_out_ready === 1'b1) begin
            pair_seen++;
            check("egress_stall", fri_prev, 1);
            if (exp_pair.size() == 0) flag("pair_unexpected", data_out);
            else check("data_out", data_out, exp_pair.pop_front());
        end else if (data_out_ready === 1'b0 && rst === 1'b0) begin
            check("data_out_idle", data_out, 0);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_key_en"}, key_en, 0);
        check({tag, "_key_out"}, key_out, 0);
        check({tag, "_data_wr"}, data_wr, 0);
        check({tag, "_text_out"}, text_out, 0);
        check({tag, "_data_out_ready"}, data_out_ready, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_pair_full"}, pair_full, 0);
        check({tag, "_text_ovf"}, text_ovf, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic send_header(int len, bit fixed, logic [DW-1:0] key_base);
        logic [DW-1:0] w;
        wr_first = 1;
        for (int k = 0; k < KEY_WORDS; k++) begin
            w = fixed ? key_base + DW'(k) : $urandom;
            exp_key.push_back(w);
            data_in = w;
            data_in_ready = 1'b1;
            tick();
        end
        data_in = DW'(len);
        tick();
        data_in_ready = 1'b0;
        data_in = '0;
    endtask

    task automatic send_text(int n, bit fixed, logic [DW-1:0] base);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = fixed ? base + DW'(i) : $urandom;
            if (ovf_mode) sent_text.push_back(w);
            else exp_text.push_back(w);
            data_in = w;
            data_in_ready = 1'b1;
            tick();
        end
        data_in_ready = 1'b0;
        data_in = '0;
    endtask

    task automatic send_pairs(int nrec, bit fixed, logic [DW-1:0] base);
        logic [DW-1:0] w;
        int t;
        for (int i = 0; i < nrec * PAIR_WORDS; i++) begin
            t = 0;
            while (pair_full === 1'b1 && t < 500) begin
                pair_in_valid = 1'b0;
                tick();
                t++;
            end
            if (pair_full === 1'b1) flag("pair_full_stuck", pair_full);
            w = fixed ? base + DW'(i) : $urandom;
            exp_pair.push_back(w);
            pair_in = w;
            pair_in_valid = 1'b1;
            tick();
        end
        pair_in_valid = 1'b0;
        pair_in = '0;
    endtask

    task automatic wait_done(string name);
        int start;
        start = done_cnt;
        jobs_exp++;
        for (int i = 0; i < 3000 && done_cnt == start; i++) tick();
        check(name, done_cnt - start, 1);
        check({name, "_keys_left"}, exp_key.size(), 0);
        check({name, "_text_left"}, exp_text.size(), 0);
        check({name, "_pairs_left"}, exp_pair.size(), 0);
    endtask

    initial begin
        int base, len;
        #500000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, len;
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_mode = 0;
        tick();

        // Basic job with a stalled pair egress
        fifo_mode = 1;
        send_header(3, 1, 32'hA0);
        send_text(3, 1, 32'h10);
        send_pairs(2, 1, 32'h1);
        check("basic_ovf", text_ovf, 0);
        wait_done("basic_done");

        // Text overflow
        fifo_mode = 0;
        ovf_mode = 1;
        send_header(100, 0, 0);
        send_text(100, 1, 32'h5000);
        check("ovf_flag", text_ovf, 1);
        wait_done("ovf_done");
        ovf_mode = 0;
        check("ovf_clear", text_ovf, 0);
        check("ovf_rcv_min", rcv_text.size() >= TEXT_DEPTH, 1);
        check("ovf_dropped", rcv_text.size() < 100, 1);
        for (int i = 0; i < rcv_text.size(); i++) begin
            if (i < TEXT_DEPTH) check("ovf_head", rcv_text[i], sent_text[i]);
            else begin
                check("ovf_order", rcv_text[i] > rcv_text[i-1], 1);
                check("ovf_range", rcv_text[i] < 32'h5000 + 100, 1);
            end
        end

        // Pair buffer full then drain
        fifo_mode = 3;
        tick();
        send_pairs(PAIR_DEPTH - 1, 0, 0);
        check("pair_not_full", pair_full, 0);
        send_pairs(1, 0, 0);
        check("pair_full_set", pair_full, 1);
        tick(); tick();
        check("pair_full_hold", pair_full, 1);
        base = pair_seen;
        fifo_mode = 0;
        for (int i = 0; i < 200 && pair_seen < base + PAIR_WORDS; i++) tick();
        check("pair_full_release", pair_full, 0);
        for (int i = 0; i < 1000 && pair_seen < base + PAIR_DEPTH * PAIR_WORDS; i++) tick();
        check("pair_drain_words", pair_seen - base, PAIR_DEPTH * PAIR_WORDS);

        // Zero length, then an immediate second job
        base = wr_total;
        send_header(0, 0, 0);
        wait_done("zero_done");
        check("zero_no_wr", wr_total - base, 0);
        send_header(4, 0, 0);
        send_text(4, 0, 0);
        wait_done("restart_done");

        // Reset in the middle of TEXT
        send_header(20, 0, 0);
        send_text(5, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_text.delete();
        exp_key.delete();
        @(negedge clk);
        check_zero("midrst");
        tick();
        send_header(6, 0, 0);
        send_text(6, 0, 0);
        wait_done("post_rst_done");

        // Randomised jobs with random router readiness
        fifo_mode = 2;
        for (int j = 0; j < 4; j++) begin
            len = $urandom_range(20, 1);
            send_header(len, 0, 0);
            send_text(len, 0, 0);
            send_pairs($urandom_range(3, 0), 0, 0);
            wait_done("rand_done");
        end

        tick(); tick();
        check("done_total", done_cnt, jobs_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
